// File: rtl/dm_access_ctrl.sv
// Load/store sequencer between the MEM stage and the word-wide dm array.
// Define DM_ALIGN_CHECK_EN to flag misaligned word/half accesses with resp_err.
module dm_access_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dm_A,
    output logic [31:0]       dm_WD,
    output logic              dm_WE,
    input  logic [31:0]       dm_RD,
    output logic [31:0]       dm_PC
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

    state_e            state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       pc_q;
    logic [31:0]       wd_q;
    logic [31:0]       rdata_q;

    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       rdata_d;
    logic [31:0]       wd_d;
    logic              req_is_word;

    // Reserved size 3 shares the word encoding pattern (both bits equal).
    assign req_is_word = (req_size[1] == req_size[0]);

    always_comb begin
        byte_lane = dm_RD[{addr_q[1:0], 3'b000} +: 8];
        half_lane = dm_RD[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'd1:    rdata_d = uns_q ? {16'h0000, half_lane} : {{16{half_lane[15]}}, half_lane};
            2'd2:    rdata_d = uns_q ? {24'h000000, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            default: rdata_d = dm_RD;
        endcase
        wd_d = dm_RD;
        if (size_q == 2'd2) begin
            wd_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (size_q == 2'd1) begin
            wd_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

`ifdef DM_ALIGN_CHECK_EN
    logic err_q;
    logic req_misaligned;

    assign req_misaligned = (req_is_word && (req_addr[1:0] != 2'b00)) ||
                            ((req_size == 2'd1) && req_addr[0]);
    assign resp_err       = err_q && (state_q == DONE);
`else
    assign resp_err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
`ifdef DM_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        pc_q    <= req_pc;
`ifdef DM_ALIGN_CHECK_EN
                        err_q   <= req_misaligned;
                        if (req_misaligned) begin
                            state_q <= DONE;
                        end else
`endif
                        if (req_we && req_is_word) begin
                            wd_q    <= req_wdata;
                            state_q <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    if (we_q) begin
                        wd_q    <= wd_d;
                        state_q <= WR;
                    end else begin
                        rdata_q <= rdata_d;
                        state_q <= DONE;
                    end
                end
                WR:      state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE) && Reset;
    assign resp_valid = (state_q == DONE);
    assign dm_WE      = (state_q == WR);
    assign dm_A       = {addr_q[ADDR_W-1:2], 2'b00};
    assign dm_WD      = wd_q;
    assign dm_PC      = pc_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed vector table plus reset,
// back-to-back and (with DM_ALIGN_CHECK_EN) misalignment sequences.
module tb_dm_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_A;
    logic [31:0] dm_WD;
    logic        dm_WE;
    logic [31:0] dm_RD;
    logic [31:0] dm_PC;

    logic [31:0] mem [0:63];

    int n_chk  = 0;
    int n_pass = 0;

    dm_access_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .Reset        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_pc       (req_pc),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dm_A         (dm_A),
        .dm_WD        (dm_WD),
        .dm_WE        (dm_WE),
        .dm_RD        (dm_RD),
        .dm_PC        (dm_PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word array behind the sequencer: combinational read, write on the edge.
    assign dm_RD = mem[dm_A[7:2]];
    always @(posedge clk) if (dm_WE) mem[dm_A[7:2]] <= dm_WD;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic        exp_err;
        int          exp_wes;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                          output int lat, output logic [31:0] rd, output logic err,
                          output int wes, output logic [31:0] wd_seen,
                          output logic [31:0] a_seen, output logic [31:0] pc_seen,
                          output logic shape_ok);
        int budget;
        lat = -1; rd = '0; err = 1'b0; wes = 0; wd_seen = '0;
        a_seen = '0; pc_seen = '0; shape_ok = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_pc = pc;
        budget = 0;
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble request fields: the sequencer must use only latched copies.
        req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_unsigned = ~uns;
        req_addr = a ^ 32'h0000_0F0C; req_wdata = ~wd; req_pc = ~pc;
        lat = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                a_seen  = dm_A;
                pc_seen = dm_PC;
            end else if (dm_A !== a_seen || dm_PC !== pc_seen) begin
                shape_ok = 1'b0;
            end
            if (req_ready) shape_ok = 1'b0;
            if (dm_WE) begin
                wes++;
                wd_seen = dm_WD;
            end
            if (resp_valid) begin
                rd  = resp_rdata;
                err = resp_err;
                break;
            end
        end
        if (!resp_valid) begin
            lat = -1;
        end else begin
            @(negedge clk);
            if (resp_valid || !req_ready) shape_ok = 1'b0;
        end
    endtask

    task automatic add(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] erd,
                       input int lat, input logic eerr, input int wes, input logic [31:0] ewd);
        vec_t v;
        v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
        v.exp_rd = erd; v.exp_lat = lat; v.exp_err = eerr; v.exp_wes = wes; v.exp_wd = ewd;
        tv.push_back(v);
    endtask

    logic        mon_en = 1'b0;
    logic        prev_rv = 1'b0;
    int          dbl = 0;
    int          bad = 0;
    logic [31:0] rq[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (resp_valid) rq.push_back(resp_rdata);
            if (resp_valid && prev_rv) dbl++;
            if (req_ready && (resp_valid || dm_WE)) bad++;
        end
        prev_rv = resp_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, wes, budget;
        logic [31:0] rd, wd_seen, a_seen, pc_seen;
        logic        err, shape_ok;
        logic [31:0] pc;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_pc = '0;

        //   we  sz    uns  addr         wdata         exp_rd        lat err wes exp_wd
        add(1, 2'd0, 0, 32'h10, 32'h5555AAAA, 32'h00000000, 2, 0, 1, 32'h5555AAAA);
        add(1, 2'd0, 0, 32'h20, 32'hDEADBEEF, 32'h00000000, 2, 0, 1, 32'hDEADBEEF);
        add(0, 2'd0, 0, 32'h20, 32'h0,        32'hDEADBEEF, 2, 0, 0, 32'h0);
`ifdef DM_ALIGN_CHECK_EN
        add(0, 2'd0, 0, 32'h21, 32'h0,        32'hDEADBEEF, 1, 1, 0, 32'h0);
        add(1, 2'd0, 0, 32'h22, 32'h01020304, 32'hDEADBEEF, 1, 1, 0, 32'h0);
        add(1, 2'd1, 0, 32'h23, 32'h00009999, 32'hDEADBEEF, 1, 1, 0, 32'h0);
`else
        add(0, 2'd0, 0, 32'h21, 32'h0,        32'hDEADBEEF, 2, 0, 0, 32'h0);
`endif
        add(0, 2'd0, 0, 32'h20, 32'h0,        32'hDEADBEEF, 2, 0, 0, 32'h0);
        add(1, 2'd0, 0, 32'h40, 32'h11223344, 32'hDEADBEEF, 2, 0, 1, 32'h11223344);
        add(1, 2'd2, 0, 32'h42, 32'h123456AA, 32'hDEADBEEF, 3, 0, 1, 32'h11AA3344);
        add(0, 2'd2, 0, 32'h42, 32'h0,        32'hFFFFFFAA, 2, 0, 0, 32'h0);
        add(0, 2'd2, 1, 32'h42, 32'h0,        32'h000000AA, 2, 0, 0, 32'h0);
        add(0, 2'd2, 0, 32'h40, 32'h0,        32'h00000044, 2, 0, 0, 32'h0);
        add(0, 2'd2, 0, 32'h43, 32'h0,        32'h00000011, 2, 0, 0, 32'h0);
        add(1, 2'd0, 0, 32'h50, 32'h80017FFF, 32'h00000011, 2, 0, 1, 32'h80017FFF);
        add(0, 2'd1, 0, 32'h52, 32'h0,        32'hFFFF8001, 2, 0, 0, 32'h0);
        add(0, 2'd1, 1, 32'h52, 32'h0,        32'h00008001, 2, 0, 0, 32'h0);
        add(0, 2'd1, 0, 32'h50, 32'h0,        32'h00007FFF, 2, 0, 0, 32'h0);
        add(1, 2'd1, 0, 32'h52, 32'hABCD1234, 32'h00007FFF, 3, 0, 1, 32'h12347FFF);
        add(0, 2'd0, 0, 32'h50, 32'h0,        32'h12347FFF, 2, 0, 0, 32'h0);
        add(0, 2'd3, 0, 32'h50, 32'h0,        32'h12347FFF, 2, 0, 0, 32'h0);
        add(0, 2'd2, 0, 32'h51, 32'h0,        32'h0000007F, 2, 0, 0, 32'h0);
        add(0, 2'd2, 0, 32'h50, 32'h0,        32'hFFFFFFFF, 2, 0, 0, 32'h0);
        add(1, 2'd2, 0, 32'h43, 32'h000000FE, 32'hFFFFFFFF, 3, 0, 1, 32'hFEAA3344);
        add(0, 2'd0, 0, 32'h40, 32'h0,        32'hFEAA3344, 2, 0, 0, 32'h0);
        add(1, 2'd1, 0, 32'h40, 32'h0000BEEF, 32'hFEAA3344, 3, 0, 1, 32'hFEAABEEF);
        add(0, 2'd1, 1, 32'h42, 32'h0,        32'h0000FEAA, 2, 0, 0, 32'h0);
        add(1, 2'd3, 0, 32'h44, 32'h0BADCAFE, 32'h0000FEAA, 2, 0, 1, 32'h0BADCAFE);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready",  {31'b0, req_ready},  32'h0);
        chk("rst_rvalid", {31'b0, resp_valid}, 32'h0);
        chk("rst_err",    {31'b0, resp_err},   32'h0);
        chk("rst_we",     {31'b0, dm_WE},      32'h0);
        chk("rst_A",      dm_A,                32'h0);
        chk("rst_WD",     dm_WD,               32'h0);
        chk("rst_PC",     dm_PC,               32'h0);
        chk("rst_rdata",  resp_rdata,          32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready",  {31'b0, req_ready},  32'h1);

        // Table-driven directed vectors
        for (int i = 0; i < tv.size(); i++) begin
            pc = 32'h0000_1000 + 32'(i * 4);
            do_req(tv[i].we, tv[i].size, tv[i].uns, tv[i].addr, tv[i].wdata, pc,
                   lat, rd, err, wes, wd_seen, a_seen, pc_seen, shape_ok);
            chk($sformatf("v%0d_lat", i),   lat,                    tv[i].exp_lat);
            chk($sformatf("v%0d_rdata", i), rd,                     tv[i].exp_rd);
            chk($sformatf("v%0d_err", i),   {31'b0, err},           {31'b0, tv[i].exp_err});
            chk($sformatf("v%0d_wes", i),   wes,                    tv[i].exp_wes);
            chk($sformatf("v%0d_A", i),     a_seen,                 tv[i].addr & 32'hFFFF_FFFC);
            chk($sformatf("v%0d_PC", i),    pc_seen,                pc);
            chk($sformatf("v%0d_shape", i), {31'b0, shape_ok},      32'h1);
            if (tv[i].exp_wes == 1) chk($sformatf("v%0d_WD", i), wd_seen, tv[i].exp_wd);
        end
        chk("mem_10", mem[32'h10 >> 2], 32'h5555AAAA);
        chk("mem_20", mem[32'h20 >> 2], 32'hDEADBEEF);
        chk("mem_40", mem[32'h40 >> 2], 32'hFEAABEEF);
        chk("mem_44", mem[32'h44 >> 2], 32'h0BADCAFE);
        chk("mem_50", mem[32'h50 >> 2], 32'h12347FFF);

        // Reset asserted in the middle of a word-store WR cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h12345678; req_pc = 32'h0000_2000;
        budget = 0;
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mid_we",   {31'b0, dm_WE}, 32'h1);
        chk("mid_A",    dm_A,           32'h10);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_we",     {31'b0, dm_WE},      32'h0);
        chk("arst_ready",  {31'b0, req_ready},  32'h0);
        chk("arst_rvalid", {31'b0, resp_valid}, 32'h0);
        repeat (2) @(negedge clk);
        chk("arst_rvalid2", {31'b0, resp_valid}, 32'h0);
        chk("arst_rdata",   resp_rdata,          32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("arel_ready",  {31'b0, req_ready},  32'h1);
        chk("arel_rvalid", {31'b0, resp_valid}, 32'h0);
        chk("arst_mem",    mem[32'h10 >> 2],    32'h5555AAAA);
        do_req(0, 2'd0, 0, 32'h10, 32'h0, 32'h0000_2004,
               lat, rd, err, wes, wd_seen, a_seen, pc_seen, shape_ok);
        chk("arst_lw",     rd,  32'h5555AAAA);
        chk("arst_lw_lat", lat, 32'd2);

        // Back-to-back: valid held high across four queued requests
        @(negedge clk);
        mon_en = 1'b1;
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_we       = (k == 0 || k == 2);
            req_size     = (k == 2) ? 2'd2 : 2'd0;
            req_unsigned = 1'b0;
            req_addr     = (k == 2) ? 32'h61 : 32'h60;
            req_wdata    = (k == 0) ? 32'hCAFEF00D : 32'h00000077;
            req_pc       = 32'h0000_3000 + 32'(k * 4);
            budget = 0;
            while (!req_ready && budget < 20) begin
                @(negedge clk);
                budget++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        budget = 0;
        while (rq.size() < 4 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        mon_en = 1'b0;
        chk("b2b_count", rq.size(), 32'd4);
        chk("b2b_dbl",   dbl,       32'd0);
        chk("b2b_ready", bad,       32'd0);
        if (rq.size() == 4) begin
            chk("b2b_r0", rq[0], 32'h5555AAAA);
            chk("b2b_r1", rq[1], 32'hCAFEF00D);
            chk("b2b_r2", rq[2], 32'hCAFEF00D);
            chk("b2b_r3", rq[3], 32'hCAFE770D);
        end
        chk("b2b_mem", mem[32'h60 >> 2], 32'hCAFE770D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
